// File: rtl/scfifo_rd_stream_pkg.sv
// Shared defaults and helpers for the SCFIFO read-side streamer.
// Holds widths/latency defaults and the in-flight popcount helper.
package scfifo_rd_stream_pkg;

  localparam int DEF_W      = 4;
  localparam int DEF_RD_LAT = 1;
  localparam int DEF_CW     = 16;
  localparam int MAX_RD_LAT = 3;
  localparam int CREDITS    = 2;

  function automatic logic [1:0] ones3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/scfifo_rd_stream_skid.sv
// skid_buf2: 2-entry register FIFO; head drives out_data.
// Ports: clk, reset, in_valid/in_data, out_valid/out_ready/out_data, cnt.
module skid_buf2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   cnt
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         acc;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign cnt       = cnt_q;
  assign acc       = out_valid & out_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    unique case ({in_valid, acc})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = in_data;
        else               tail_d = in_data;
        if (cnt_q != 2'd2) cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // head leaves, new word goes behind whatever remains
        if (cnt_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/scfifo_rd_stream.sv
// Read-side master for SCFIFO: credit-gated pops, latency pipe, stream out.
// Ports: clk, reset, en, fifo_empty/fifo_rd_n/fifo_data, dout/dout_valid/dout_ready, pop_count.
module scfifo_rd_stream
  import scfifo_rd_stream_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int CW     = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          fifo_empty,
  output logic          fifo_rd_n,
  input  logic [W-1:0]  fifo_data,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [CW-1:0] pop_count
);

  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [RD_LAT:0]   pipe_ext;
  logic [2:0]        pipe3;
  logic [1:0]        inflight;
  logic [1:0]        cnt;
  logic [2:0]        used;
  logic              accept;
  logic              capture;
  logic              pop;
  logic [CW-1:0]     pop_count_q, pop_count_d;

  always_comb begin
    pipe3 = '0;
    pipe3[RD_LAT-1:0] = pipe_q;
  end

  assign inflight = ones3(pipe3);
  assign accept   = dout_valid & dout_ready;
  assign capture  = pipe_q[RD_LAT-1];

  // a word leaving this cycle frees its slot for a new pop
  assign used = 3'(cnt) + 3'(inflight) - 3'(accept);

  assign pop = en & ~fifo_empty & (used < 3'(CREDITS)) & ~reset;

  assign fifo_rd_n = ~pop;

  assign pipe_ext    = {pipe_q, pop};
  assign pipe_d      = pipe_ext[RD_LAT-1:0];
  assign pop_count_d = pop_count_q + CW'(pop);
  assign pop_count   = pop_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q      <= '0;
      pop_count_q <= '0;
    end else begin
      pipe_q      <= pipe_d;
      pop_count_q <= pop_count_d;
    end
  end

  skid_buf2 #(.W(W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (capture),
    .in_data   (fifo_data),
    .out_valid (dout_valid),
    .out_ready (dout_ready),
    .out_data  (dout),
    .cnt       (cnt)
  );

endmodule

// File: tb/tb_scfifo_rd_stream.sv
// Scoreboard bench for scfifo_rd_stream with a queue-based FIFO model.
// Popped words go to an expected queue; a monitor compares accepted words.
module tb_scfifo_rd_stream;

  localparam int W      = 4;
  localparam int RD_LAT = 1;
  localparam int CW     = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b1;
  logic          dout_ready = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_n;
  logic [W-1:0]  fifo_data;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic [CW-1:0] pop_count;

  always #5 clk = ~clk;

  scfifo_rd_stream #(.W(W), .RD_LAT(RD_LAT), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_rd_n  (fifo_rd_n),
    .fifo_data  (fifo_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .pop_count  (pop_count)
  );

  int pass_n = 0;
  int total_n = 0;

  task automatic chk(input string nm, input int act, input int req);
    total_n++;
    if (act == req) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endtask

  logic [W-1:0] pend[$];
  logic [W-1:0] fq[$];
  logic [W-1:0] expq[$];
  logic [W-1:0] dp [RD_LAT] = '{default: '0};
  int pops = 0;
  int pops_base = 0;

  assign fifo_data = dp[RD_LAT-1];

  // FIFO model: pop on low strobe, data emerges RD_LAT cycles later
  always @(posedge clk) begin
    logic [W-1:0] w;
    if (!fifo_rd_n) begin
      chk("pop_nonempty", int'(fq.size() != 0), 1);
      if (fq.size() != 0) begin
        w = fq.pop_front();
        expq.push_back(w);
        dp[0] <= w;
      end
      pops++;
    end
    for (int i = 1; i < RD_LAT; i++) dp[i] <= dp[i-1];
    while (pend.size() != 0) fq.push_back(pend.pop_front());
    fifo_empty <= (fq.size() == 0);
  end

  int cyc = 0;
  int acc_cyc[$];
  logic hold = 1'b0;
  logic [W-1:0] hd = '0;

  always @(posedge clk) begin
    logic [W-1:0] e;
    if (!reset) begin
      if (hold) begin
        chk("hold_valid", int'(dout_valid), 1);
        chk("hold_data", int'(dout), int'(hd));
      end
      if (dout_valid && dout_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_word", int'(dout), -1);
        end else begin
          e = expq.pop_front();
          chk("stream_data", int'(dout), int'(e));
        end
        acc_cyc.push_back(cyc);
      end
      hold = dout_valid && !dout_ready;
      hd = dout;
    end else begin
      hold = 1'b0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!reset && expq.size() > 2)
      chk("credit_bound", int'(expq.size()), 2);
  end

  task automatic load(input int n, input int start);
    for (int i = 0; i < n; i++) pend.push_back(W'(start + i));
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((pend.size() != 0 || fq.size() != 0 || expq.size() != 0)
           && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    @(negedge clk);
    if (k >= budget) chk("drain_timeout", 0, 1);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    expq.delete();
    #1;
    for (int i = 0; i < n; i++) begin
      chk("rst_rd_n", int'(fifo_rd_n), 1);
      chk("rst_valid", int'(dout_valid), 0);
      chk("rst_pop_count", int'(pop_count), 0);
      chk("rst_dout", int'(dout), 0);
      @(negedge clk);
    end
    pops_base = pops;
    reset = 1'b0;
  endtask

  function automatic int exp_pc();
    return (pops - pops_base) % 16;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    // reset holds off pops even with data present and en=1
    load(8, 1);
    apply_reset(4);
    acc_cyc.delete();
    wait_drain(60);
    chk("stream_pop_count", int'(pop_count), 8);
    chk("stream_rd_n_idle", int'(fifo_rd_n), 1);
    chk("stream_words", acc_cyc.size(), 8);
    if (acc_cyc.size() == 8)
      chk("stream_back_to_back", acc_cyc[7] - acc_cyc[0], 7);

    // backpressure: only two credits worth of pops
    dout_ready = 1'b0;
    p0 = pops;
    load(5, 1);
    repeat (8) @(negedge clk);
    chk("bp_pops", pops - p0, 2);
    chk("bp_rd_n", int'(fifo_rd_n), 1);
    chk("bp_valid", int'(dout_valid), 1);
    chk("bp_head", int'(dout), 1);
    dout_ready = 1'b1;
    wait_drain(60);
    chk("bp_pop_count", int'(pop_count), exp_pc());

    // en low: no pops
    en = 1'b0;
    p0 = pops;
    load(4, 9);
    repeat (6) begin
      @(negedge clk);
      chk("en_off_rd_n", int'(fifo_rd_n), 1);
    end
    chk("en_off_pops", pops - p0, 0);
    en = 1'b1;
    wait_drain(60);

    // empty FIFO: no pops
    p0 = pops;
    repeat (5) @(negedge clk);
    chk("empty_pops", pops - p0, 0);

    // en dropped mid-burst: in-flight words still arrive
    load(8, 3);
    repeat (4) @(negedge clk);
    en = 1'b0;
    #1;
    chk("en_drop_rd_n", int'(fifo_rd_n), 1);
    p0 = pops;
    repeat (6) @(negedge clk);
    chk("en_drop_pops", pops - p0, 0);
    chk("en_drop_flushed", expq.size(), 0);
    en = 1'b1;
    wait_drain(60);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(2) == 0 && fq.size() < 20)
        pend.push_back(W'($urandom));
      dout_ready = ($urandom_range(3) != 0);
      en = ($urandom_range(7) != 0);
    end
    en = 1'b1;
    dout_ready = 1'b1;
    wait_drain(200);
    chk("rand_pop_count", int'(pop_count), exp_pc());

    // reset with words buffered: they must be dropped
    dout_ready = 1'b0;
    load(5, 1);
    repeat (3) @(negedge clk);
    chk("mid_outstanding", expq.size(), 2);
    chk("mid_valid", int'(dout_valid), 1);
    apply_reset(2);
    dout_ready = 1'b1;
    wait_drain(60);
    chk("mid_pop_count", int'(pop_count), 3);

    // pop_count wraps at 16 with CW=4
    apply_reset(1);
    load(16, 0);
    wait_drain(80);
    chk("wrap_pop_count", int'(pop_count), exp_pc());
    chk("wrap_zero", int'(pop_count), 0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
